apb_master_bridge: RTL and testbench



---
 rtl/apb_master_bridge_if.sv | 52 +++++
 rtl/apb_master_bridge.sv | 132 +++++++++++++
 tb/tb_apb_master_bridge.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_if.sv
// Command/response handshake plus APB4 bus bundle
// for the requester-side APB master bridge.
interface apb_master_bridge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  localparam int SW = DATA_WIDTH / 8;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [SW-1:0]         cmd_strb;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [SW-1:0]         PSTRB;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  SLVERROR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr,
    input  cmd_wdata, cmd_strb,
    input  PREADY, PRDATA, SLVERROR,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output rsp_timeout,
    output PADDR, PSEL, PENABLE, PWRITE,
    output PWDATA, PSTRB
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr,
    output cmd_wdata, cmd_strb,
    output PREADY, PRDATA, SLVERROR,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  rsp_timeout,
    input  PADDR, PSEL, PENABLE, PWRITE,
    input  PWDATA, PSTRB
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB4 master: valid/ready commands in, SETUP/ACCESS
// transfers out, one-cycle response pulse with timeout.
module apb_master_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic PCLK,
  input logic PRESETn,
  apb_master_bridge_if.master bus
);
  localparam int SW = DATA_WIDTH / 8;
  localparam bit TO_EN = TIMEOUT_CYCLES > 0;
  localparam int CW =
    TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST =
    TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [SW-1:0]         pstrb_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  rsp_to_q;

  logic in_access;
  logic timeout_hit;
  logic accept;

  assign in_access = state == ACCESS;
  assign timeout_hit = TO_EN && in_access &&
    cnt == TO_LAST && !bus.PREADY;

  assign bus.cmd_ready = (state == IDLE) ||
    (in_access && bus.PREADY && !timeout_hit);
  assign accept = bus.cmd_valid && bus.cmd_ready;

  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.PSTRB       = pstrb_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_to_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      cnt         <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      // reads never present strobes on the bus
      if (accept) begin
        paddr_q  <= bus.cmd_addr;
        pwrite_q <= bus.cmd_write;
        pwdata_q <= bus.cmd_wdata;
        pstrb_q  <= bus.cmd_write ?
                    bus.cmd_strb : '0;
      end
      unique case (state)
        IDLE: begin
          if (accept) begin
            state     <= SETUP;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
          end
        end
        SETUP: begin
          state     <= ACCESS;
          penable_q <= 1'b1;
          cnt       <= '0;
        end
        ACCESS: begin
          if (bus.PREADY) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pwrite_q ?
                           '0 : bus.PRDATA;
            rsp_err_q   <= bus.SLVERROR;
            rsp_to_q    <= 1'b0;
            penable_q   <= 1'b0;
            if (accept) begin
              state <= SETUP;
            end else begin
              state  <= IDLE;
              psel_q <= 1'b0;
            end
          end else if (timeout_hit) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            rsp_to_q    <= 1'b1;
            state       <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
          end else if (TO_EN) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed table, corner
// sequences and random traffic against a transaction model.
module tb_apb_master_bridge;
  localparam int TO = 4;

  logic PCLK;
  logic PRESETn;
  int   checks;
  int   errors;
  int   cyc;

  apb_master_bridge_if #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(8)
  ) bus ();

  apb_master_bridge #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(8),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .bus(bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               n, act, exp);
    end
  endtask

  typedef struct {
    logic        w;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    int          wt;
    logic        e;
    int          acc;
  } txn_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        to;
    int          due;
  } rsp_t;

  // stimulus-chosen slave behaviour for the next command
  int   plan_w;
  logic plan_e;
  int   plan_wq[$];
  logic plan_eq[$];

  logic [31:0] smem [256];
  logic [31:0] mmem [256];
  txn_t pend[$];
  rsp_t rq[$];
  int   rsp_cycs[$];

  // APB slave: wait states and error from the plan
  int   s_wait;
  int   s_wcnt;
  logic s_err;
  always begin
    @(posedge PCLK);
    #1;
    if (!PRESETn) begin
      bus.PREADY = 1'b0;
      s_wcnt = 0;
    end else if (bus.PSEL && !bus.PENABLE) begin
      s_wait = 0;
      s_err  = 1'b0;
      if (plan_wq.size() > 0) begin
        s_wait = plan_wq.pop_front();
        s_err  = plan_eq.pop_front();
      end
      s_wcnt = 0;
      bus.PREADY   = 1'b0;
      bus.PRDATA   = $urandom;
      bus.SLVERROR = 1'($urandom_range(0, 1));
    end else if (bus.PSEL && bus.PENABLE) begin
      if (s_wcnt == s_wait) begin
        bus.PREADY   = 1'b1;
        bus.PRDATA   = smem[bus.PADDR];
        bus.SLVERROR = s_err;
      end else begin
        bus.PREADY   = 1'b0;
        bus.PRDATA   = $urandom;
        bus.SLVERROR = 1'($urandom_range(0, 1));
        s_wcnt++;
      end
    end else begin
      bus.PREADY   = 1'($urandom_range(0, 1));
      bus.PRDATA   = $urandom;
      bus.SLVERROR = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge PCLK) begin
    if (PRESETn && bus.PSEL && bus.PENABLE &&
        bus.PREADY && bus.PWRITE) begin
      for (int b = 0; b < 4; b++)
        if (bus.PSTRB[b])
          smem[bus.PADDR][8*b +: 8] =
            bus.PWDATA[8*b +: 8];
    end
  end

  // transaction model: timing from accept cycle and plan
  txn_t m_t;
  rsp_t m_r;
  int   m_ph;
  int   m_last;
  logic m_rdy;
  always @(negedge PCLK) begin
    cyc++;
    if (PRESETn) begin
      m_rdy = pend.size() == 0;
      if (pend.size() > 0) begin
        m_t  = pend[0];
        m_ph = cyc - m_t.acc;
        m_last = 2 + ((m_t.wt < TO) ? m_t.wt : TO - 1);
        chk("psel", 32'(bus.PSEL), 32'd1);
        chk("penable", 32'(bus.PENABLE),
            32'(m_ph >= 2));
        chk("paddr", 32'(bus.PADDR), 32'(m_t.a));
        chk("pwrite", 32'(bus.PWRITE), 32'(m_t.w));
        chk("pwdata", bus.PWDATA, m_t.d);
        chk("pstrb", 32'(bus.PSTRB),
            32'(m_t.w ? m_t.s : 4'h0));
        if (m_ph == m_last) begin
          m_r.due = cyc + 1;
          if (m_t.wt >= TO) begin
            m_r.rd  = 32'h0;
            m_r.err = 1'b1;
            m_r.to  = 1'b1;
          end else begin
            m_r.rd  = m_t.w ? 32'h0 : mmem[m_t.a];
            m_r.err = m_t.e;
            m_r.to  = 1'b0;
            m_rdy   = 1'b1;
            if (m_t.w)
              for (int b = 0; b < 4; b++)
                if (m_t.s[b])
                  mmem[m_t.a][8*b +: 8] =
                    m_t.d[8*b +: 8];
          end
          rq.push_back(m_r);
          pend.delete(0);
        end
      end else begin
        chk("idle_psel", 32'(bus.PSEL), 32'd0);
        chk("idle_penable", 32'(bus.PENABLE), 32'd0);
      end
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(m_rdy));
      if (rq.size() > 0 && rq[0].due == cyc) begin
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_rdata", bus.rsp_rdata, rq[0].rd);
        chk("rsp_err", 32'(bus.rsp_err),
            32'(rq[0].err));
        chk("rsp_timeout", 32'(bus.rsp_timeout),
            32'(rq[0].to));
        rq.delete(0);
        rsp_cycs.push_back(cyc);
      end else begin
        chk("rsp_quiet", 32'(bus.rsp_valid), 32'd0);
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        pend.push_back('{bus.cmd_write, bus.cmd_addr,
                         bus.cmd_wdata, bus.cmd_strb,
                         plan_w, plan_e, cyc});
        plan_wq.push_back(plan_w);
        plan_eq.push_back(plan_e);
      end
    end
  end

  // called and returning at posedge+1
  task automatic issue(input logic w,
                       input logic [7:0] a,
                       input logic [31:0] d,
                       input logic [3:0] s,
                       input int wt,
                       input logic e,
                       input bit hold);
    logic acc;
    acc = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_strb  = s;
    plan_w = wt;
    plan_e = e;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge PCLK);
      acc = bus.cmd_ready;
      @(posedge PCLK);
      #1;
    end
    chk("accept", 32'(acc), 32'd1);
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [31:0] rd,
                          output logic err,
                          output logic to,
                          output logic got);
    got = 1'b0;
    rd  = 32'h0;
    err = 1'b0;
    to  = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge PCLK);
      if (bus.rsp_valid) begin
        got = 1'b1;
        rd  = bus.rsp_rdata;
        err = bus.rsp_err;
        to  = bus.rsp_timeout;
      end
    end
    @(posedge PCLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  typedef struct {
    logic        w;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    int          wt;
    logic        e;
    logic [31:0] x_rd;
    logic        x_err;
    logic        x_to;
  } vec_t;

  vec_t        tbl[11];
  logic [31:0] g_rd;
  logic        g_err;
  logic        g_to;
  logic        g_got;
  int          n;
  bit          hold;
  int          r;
  int          wt;

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    plan_w = 0;
    plan_e = 1'b0;
    for (int i = 0; i < 256; i++) begin
      smem[i] = 32'h0;
      mmem[i] = 32'h0;
    end
    tbl[0]  = '{1'b1, 8'h10, 32'hDEADBEEF, 4'hF,
                0, 1'b0, 32'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 8'h10, 32'h0, 4'h3,
                0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 8'h30, 32'hAABBCCDD, 4'h6,
                1, 1'b0, 32'h0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 8'h30, 32'h0, 4'hF,
                0, 1'b0, 32'h00BBCC00, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 8'h40, 32'h12345678, 4'hF,
                3, 1'b1, 32'h0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 8'h40, 32'h0, 4'h0,
                0, 1'b0, 32'h12345678, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 8'h10, 32'h0, 4'h0,
                9, 1'b0, 32'h0, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 8'h10, 32'h0, 4'h0,
                3, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 8'h50, 32'hCAFEF00D, 4'hF,
                9, 1'b0, 32'h0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 8'h50, 32'h0, 4'h0,
                0, 1'b0, 32'h0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'h10, 32'h0, 4'h0,
                2, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0};

    PRESETn       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h0;
    bus.cmd_wdata = 32'h0;
    bus.cmd_strb  = 4'h0;
    idle(3);
    chk("rst_psel", 32'(bus.PSEL), 32'd0);
    chk("rst_penable", 32'(bus.PENABLE), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_paddr", 32'(bus.PADDR), 32'd0);
    chk("rst_pstrb", 32'(bus.PSTRB), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    PRESETn = 1'b1;
    idle(2);

    for (int i = 0; i < 11; i++) begin
      issue(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s,
            tbl[i].wt, tbl[i].e, 1'b0);
      wait_rsp(g_rd, g_err, g_to, g_got);
      chk($sformatf("tbl%0d_got", i),
          32'(g_got), 32'd1);
      chk($sformatf("tbl%0d_rdata", i),
          g_rd, tbl[i].x_rd);
      chk($sformatf("tbl%0d_err", i),
          32'(g_err), 32'(tbl[i].x_err));
      chk($sformatf("tbl%0d_timeout", i),
          32'(g_to), 32'(tbl[i].x_to));
      idle(1);
    end

    // back-to-back writes with cmd_valid held
    rsp_cycs.delete();
    issue(1'b1, 8'h00, 32'h11111111, 4'hF, 0, 1'b0, 1);
    issue(1'b1, 8'h04, 32'h22222222, 4'hF, 0, 1'b0, 1);
    issue(1'b1, 8'h08, 32'h33333333, 4'hF, 0, 1'b0, 0);
    idle(8);
    n = rsp_cycs.size();
    chk("b2b_pulses", 32'(n), 32'd3);
    if (n == 3) begin
      chk("b2b_gap1", 32'(rsp_cycs[1] - rsp_cycs[0]),
          32'd2);
      chk("b2b_gap2", 32'(rsp_cycs[2] - rsp_cycs[1]),
          32'd2);
    end

    // reset in the middle of a stalled read
    issue(1'b0, 8'h10, 32'h0, 4'h0, 9, 1'b0, 0);
    repeat (3) @(negedge PCLK);
    #2;
    PRESETn = 1'b0;
    pend.delete();
    rq.delete();
    plan_wq.delete();
    plan_eq.delete();
    #1;
    chk("arst_psel", 32'(bus.PSEL), 32'd0);
    chk("arst_penable", 32'(bus.PENABLE), 32'd0);
    chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    idle(2);
    PRESETn = 1'b1;
    idle(8);
    issue(1'b0, 8'h10, 32'h0, 4'h0, 0, 1'b0, 0);
    wait_rsp(g_rd, g_err, g_to, g_got);
    chk("post_rst_got", 32'(g_got), 32'd1);
    chk("post_rst_rdata", g_rd, 32'hDEADBEEF);
    chk("post_rst_err", 32'(g_err), 32'd0);

    // random traffic, model checks every cycle
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5) wt = 0;
      else if (r < 8) wt = $urandom_range(1, 3);
      else if (r == 8) wt = 3;
      else wt = $urandom_range(4, 6);
      hold = ($urandom_range(0, 2) == 0) && i != 199;
      issue(1'($urandom_range(0, 1)),
            8'($urandom_range(0, 15) * 4),
            $urandom,
            4'($urandom_range(0, 15)),
            wt,
            1'($urandom_range(0, 3) == 0),
            hold);
      if (!hold) idle($urandom_range(0, 2));
    end
    for (int i = 0; i < 60; i++)
      if (pend.size() + rq.size() > 0)
        @(negedge PCLK);
    chk("drain", 32'(pend.size() + rq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
